// File: rtl/lcd_timing_pkg.sv
// Shared constants for the parallel RGB LCD timing generator:
// default panel timing, coordinate width and the colour-bar palette.
package lcd_timing_pkg;

   // Default panel timing (480x272 class panel).
   localparam int DEF_H_ACTIVE = 480;
   localparam int DEF_H_FP     = 8;
   localparam int DEF_H_SYNC   = 4;
   localparam int DEF_H_BP     = 43;
   localparam int DEF_V_ACTIVE = 272;
   localparam int DEF_V_FP     = 8;
   localparam int DEF_V_SYNC   = 4;
   localparam int DEF_V_BP     = 12;

   localparam int DEF_H_TOTAL  = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
   localparam int DEF_V_TOTAL  = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

   // Width of the pixel/line counters and of the X/Y coordinates.
   localparam int COORD_W      = 11;
   localparam int COORD_MAX    = 2047;

   // Colour bars, left to right, packed as {R,G,B}.
   localparam logic [23:0] BAR_WHITE   = 24'hFFFFFF;
   localparam logic [23:0] BAR_YELLOW  = 24'hFFFF00;
   localparam logic [23:0] BAR_CYAN    = 24'h00FFFF;
   localparam logic [23:0] BAR_GREEN   = 24'h00FF00;
   localparam logic [23:0] BAR_MAGENTA = 24'hFF00FF;
   localparam logic [23:0] BAR_RED     = 24'hFF0000;
   localparam logic [23:0] BAR_BLUE    = 24'h0000FF;
   localparam logic [23:0] BAR_BLACK   = 24'h000000;

   // Colour of bar number idx (0 = leftmost).
   function automatic logic [23:0] bar_colour(input logic [2:0] idx);
      logic [23:0] c;
      case (idx)
         3'd0:    c = BAR_WHITE;
         3'd1:    c = BAR_YELLOW;
         3'd2:    c = BAR_CYAN;
         3'd3:    c = BAR_GREEN;
         3'd4:    c = BAR_MAGENTA;
         3'd5:    c = BAR_RED;
         3'd6:    c = BAR_BLUE;
         default: c = BAR_BLACK;
      endcase
      return c;
   endfunction

   // Pin level of a sync signal given whether it is in its pulse.
   function automatic logic sync_level(input logic active, input logic pol);
      logic lvl;
      if (active) begin
         lvl = pol;
      end else begin
         lvl = ~pol;
      end
      return lvl;
   endfunction

endpackage

// File: rtl/lcd_delay_line.sv
// Fixed-depth shift register with asynchronous active-low reset to a
// parameterised value. Used to align timing signals with client colour.
module lcd_delay_line
   import lcd_timing_pkg::*;
#(
   parameter int               DEPTH   = 1,
   parameter int               WIDTH   = 1,
   parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}}
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout
);

   logic [WIDTH-1:0] stage_r [DEPTH];

   // Shift din through DEPTH register stages; all stages reset to RST_VAL.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            stage_r[i] <= RST_VAL;
         end
      end else begin
         stage_r[0] <= din;
         for (int i = 1; i < DEPTH; i++) begin
            stage_r[i] <= stage_r[i-1];
         end
      end
   end

   assign dout = stage_r[DEPTH-1];

endmodule

// File: rtl/lcd_timing_gen.sv
// Pixel-interface master for a parallel RGB LCD.
//  - Counter stage: hcnt/vcnt, registered DEN/X/Y to the client, raw syncs
//    and a FRAME_START strobe, all undelayed.
//  - Alignment: raw DE/HS/VS delayed by CLIENT_LAT to meet the client's
//    registered colour, then one common output register so every panel
//    pin changes on the same edge. Colour is forced to zero in blanking.
// Optional build macro LCD_TEST_PATTERN_EN adds PATTERN_SEL, which replaces
// client colour by eight vertical colour bars computed from delayed X.
module lcd_timing_gen
   import lcd_timing_pkg::*;
#(
   parameter int H_ACTIVE   = DEF_H_ACTIVE,
   parameter int H_FP       = DEF_H_FP,
   parameter int H_SYNC     = DEF_H_SYNC,
   parameter int H_BP       = DEF_H_BP,
   parameter int V_ACTIVE   = DEF_V_ACTIVE,
   parameter int V_FP       = DEF_V_FP,
   parameter int V_SYNC     = DEF_V_SYNC,
   parameter int V_BP       = DEF_V_BP,
   parameter bit SYNC_POL   = 1'b0,
   parameter int CLIENT_LAT = 1
) (
   input  logic               CLK,
   input  logic               RST_IN,
`ifdef LCD_TEST_PATTERN_EN
   input  logic               PATTERN_SEL,
`endif
   output logic               DEN,
   output logic [COORD_W-1:0] X,
   output logic [COORD_W-1:0] Y,
   input  logic [7:0]         R,
   input  logic [7:0]         G,
   input  logic [7:0]         B,
   output logic [7:0]         LCD_R,
   output logic [7:0]         LCD_G,
   output logic [7:0]         LCD_B,
   output logic               LCD_DE,
   output logic               LCD_HSYNC,
   output logic               LCD_VSYNC,
   output logic               FRAME_START
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   // Parameter sanity, rejected at elaboration.
   generate
      if ((CLIENT_LAT < 1) || (CLIENT_LAT > 4)) begin : g_bad_lat
         $error("lcd_timing_gen: CLIENT_LAT must be in 1..4");
      end
      if ((H_TOTAL > COORD_MAX) || (V_TOTAL > COORD_MAX)) begin : g_bad_total
         $error("lcd_timing_gen: H_TOTAL/V_TOTAL exceed the 11-bit counters");
      end
   endgenerate

   localparam logic [COORD_W-1:0] H_ACT_C    = COORD_W'(H_ACTIVE);
   localparam logic [COORD_W-1:0] H_LAST_C   = COORD_W'(H_TOTAL - 1);
   localparam logic [COORD_W-1:0] HS_FIRST_C = COORD_W'(H_ACTIVE + H_FP);
   localparam logic [COORD_W-1:0] HS_LAST_C  = COORD_W'(H_ACTIVE + H_FP + H_SYNC - 1);
   localparam logic [COORD_W-1:0] V_ACT_C    = COORD_W'(V_ACTIVE);
   localparam logic [COORD_W-1:0] V_LAST_C   = COORD_W'(V_TOTAL - 1);
   localparam logic [COORD_W-1:0] VS_FIRST_C = COORD_W'(V_ACTIVE + V_FP);
   localparam logic [COORD_W-1:0] VS_LAST_C  = COORD_W'(V_ACTIVE + V_FP + V_SYNC - 1);
   localparam logic               SYNC_IDLE  = ~SYNC_POL;

   // Counter stage
   logic [COORD_W-1:0] hcnt_r;
   logic [COORD_W-1:0] vcnt_r;
   logic [COORD_W-1:0] hcnt_nxt_s;
   logic [COORD_W-1:0] vcnt_nxt_s;
   logic               h_wrap_s;
   logic               de_raw_s;
   logic               hs_raw_s;
   logic               vs_raw_s;
   logic               den_r;
   logic [COORD_W-1:0] x_r;
   logic [COORD_W-1:0] y_r;
   logic               hs_r;
   logic               vs_r;
   logic               frame_start_r;

   // Alignment and output stage
   logic [2:0]         pipe_in_s;
   logic [2:0]         pipe_out_s;
   logic               de_dly_s;
   logic               hs_dly_s;
   logic               vs_dly_s;
   logic [23:0]        colour_s;
   logic [23:0]        lcd_rgb_r;
   logic               lcd_de_r;
   logic               lcd_hs_r;
   logic               lcd_vs_r;

   // Next counter values: hcnt wraps each line, vcnt advances on hcnt wrap.
   always_comb begin
      h_wrap_s = (hcnt_r == H_LAST_C);
      if (h_wrap_s) begin
         hcnt_nxt_s = {COORD_W{1'b0}};
         if (vcnt_r == V_LAST_C) begin
            vcnt_nxt_s = {COORD_W{1'b0}};
         end else begin
            vcnt_nxt_s = vcnt_r + 11'd1;
         end
      end else begin
         hcnt_nxt_s = hcnt_r + 11'd1;
         vcnt_nxt_s = vcnt_r;
      end
   end

   // Decode active region and sync pulses from the current counter position.
   always_comb begin
      de_raw_s = (hcnt_r < H_ACT_C) && (vcnt_r < V_ACT_C);
      hs_raw_s = sync_level((hcnt_r >= HS_FIRST_C) && (hcnt_r <= HS_LAST_C), SYNC_POL);
      vs_raw_s = sync_level((vcnt_r >= VS_FIRST_C) && (vcnt_r <= VS_LAST_C), SYNC_POL);
   end

   // Counter stage: advance counters and register the client-side view.
   // After reset the counters sit at 0,0 so the first edge presents pixel
   // (0,0) together with FRAME_START.
   always_ff @(posedge CLK or negedge RST_IN) begin
      if (!RST_IN) begin
         hcnt_r        <= {COORD_W{1'b0}};
         vcnt_r        <= {COORD_W{1'b0}};
         den_r         <= 1'b0;
         x_r           <= {COORD_W{1'b0}};
         y_r           <= {COORD_W{1'b0}};
         hs_r          <= SYNC_IDLE;
         vs_r          <= SYNC_IDLE;
         frame_start_r <= 1'b0;
      end else begin
         hcnt_r        <= hcnt_nxt_s;
         vcnt_r        <= vcnt_nxt_s;
         den_r         <= de_raw_s;
         x_r           <= de_raw_s ? hcnt_r : {COORD_W{1'b0}};
         y_r           <= de_raw_s ? vcnt_r : {COORD_W{1'b0}};
         hs_r          <= hs_raw_s;
         vs_r          <= vs_raw_s;
         frame_start_r <= (hcnt_r == {COORD_W{1'b0}}) && (vcnt_r == {COORD_W{1'b0}});
      end
   end

   // Delay DE/HS/VS by the client latency so they line up with R/G/B.
   assign pipe_in_s = {den_r, hs_r, vs_r};

   lcd_delay_line #(
      .DEPTH   (CLIENT_LAT),
      .WIDTH   (3),
      .RST_VAL ({1'b0, SYNC_IDLE, SYNC_IDLE})
   ) u_sync_dly (
      .clk   (CLK),
      .rst_n (RST_IN),
      .din   (pipe_in_s),
      .dout  (pipe_out_s)
   );

   assign de_dly_s = pipe_out_s[2];
   assign hs_dly_s = pipe_out_s[1];
   assign vs_dly_s = pipe_out_s[0];

`ifdef LCD_TEST_PATTERN_EN
   localparam logic [COORD_W-1:0] BAR_W_C = COORD_W'(H_ACTIVE / 8);

   logic [COORD_W-1:0] x_dly_s;
   logic [2:0]         bar_idx_s;

   // X follows the same delay as DE so the bars share the client latency.
   lcd_delay_line #(
      .DEPTH   (CLIENT_LAT),
      .WIDTH   (COORD_W),
      .RST_VAL ({COORD_W{1'b0}})
   ) u_x_dly (
      .clk   (CLK),
      .rst_n (RST_IN),
      .din   (x_r),
      .dout  (x_dly_s)
   );

   assign bar_idx_s = 3'(x_dly_s / BAR_W_C);

   // Select test bars or client colour for the output stage.
   always_comb begin
      colour_s = {R, G, B};
      if (PATTERN_SEL) begin
         colour_s = bar_colour(bar_idx_s);
      end else begin
         colour_s = {R, G, B};
      end
   end
`else
   // Client colour is the only source in this build.
   always_comb begin
      colour_s = {R, G, B};
   end
`endif

   // Output stage: one register for every panel pin; colour zeroed in blanking.
   always_ff @(posedge CLK or negedge RST_IN) begin
      if (!RST_IN) begin
         lcd_rgb_r <= 24'h000000;
         lcd_de_r  <= 1'b0;
         lcd_hs_r  <= SYNC_IDLE;
         lcd_vs_r  <= SYNC_IDLE;
      end else begin
         lcd_rgb_r <= de_dly_s ? colour_s : 24'h000000;
         lcd_de_r  <= de_dly_s;
         lcd_hs_r  <= hs_dly_s;
         lcd_vs_r  <= vs_dly_s;
      end
   end

   assign DEN         = den_r;
   assign X           = x_r;
   assign Y           = y_r;
   assign FRAME_START = frame_start_r;
   assign LCD_R       = lcd_rgb_r[23:16];
   assign LCD_G       = lcd_rgb_r[15:8];
   assign LCD_B       = lcd_rgb_r[7:0];
   assign LCD_DE      = lcd_de_r;
   assign LCD_HSYNC   = lcd_hs_r;
   assign LCD_VSYNC   = lcd_vs_r;

endmodule

// File: tb/tb_lcd_timing_gen.sv
// Bench for lcd_timing_gen: three instances (default timing with latency 1,
// small timing active-high syncs latency 1, small timing latency 3), each
// paired with a registered client model. Every cycle the outputs are
// compared against a position-based reference computed from the cycle
// index since reset release.
module tb_lcd_timing_gen;

   localparam int SH_A = 16, SH_F = 3, SH_S = 2, SH_B = 4;
   localparam int SV_A = 5,  SV_F = 2, SV_S = 2, SV_B = 3;

`ifdef LCD_TEST_PATTERN_EN
   localparam bit PAT_EN = 1'b1;
`else
   localparam bit PAT_EN = 1'b0;
`endif

   typedef struct packed {
      logic        den;
      logic [10:0] x;
      logic [10:0] y;
      logic        fs;
      logic        lde;
      logic        lhs;
      logic        lvs;
      logic [23:0] rgb;
   } exp_t;

   logic CLK = 1'b0;
   logic rst_n;
   logic pat_sel;
   bit   pat_on;
   int   seed_g, seed_b;
   int   vec_cnt = 0;
   int   err_cnt = 0;

   always #5 CLK = ~CLK;

   logic d_den, d_fs, d_lde, d_lhs, d_lvs;
   logic [10:0] d_x, d_y;
   logic [7:0] d_r, d_g, d_b, d_lr, d_lg, d_lb;
   logic a_den, a_fs, a_lde, a_lhs, a_lvs;
   logic [10:0] a_x, a_y;
   logic [7:0] a_r, a_g, a_b, a_lr, a_lg, a_lb;
   logic b_den, b_fs, b_lde, b_lhs, b_lvs;
   logic [10:0] b_x, b_y;
   logic [7:0] b_r, b_g, b_b, b_lr, b_lg, b_lb;

   logic [23:0] d_hist [4];
   logic [23:0] a_hist [4];
   logic [23:0] b_hist [4];

   lcd_timing_gen u_def (
      .CLK(CLK), .RST_IN(rst_n),
`ifdef LCD_TEST_PATTERN_EN
      .PATTERN_SEL(pat_sel),
`endif
      .DEN(d_den), .X(d_x), .Y(d_y), .R(d_r), .G(d_g), .B(d_b),
      .LCD_R(d_lr), .LCD_G(d_lg), .LCD_B(d_lb), .LCD_DE(d_lde),
      .LCD_HSYNC(d_lhs), .LCD_VSYNC(d_lvs), .FRAME_START(d_fs));

   lcd_timing_gen #(
      .H_ACTIVE(SH_A), .H_FP(SH_F), .H_SYNC(SH_S), .H_BP(SH_B),
      .V_ACTIVE(SV_A), .V_FP(SV_F), .V_SYNC(SV_S), .V_BP(SV_B),
      .SYNC_POL(1'b1), .CLIENT_LAT(1)
   ) u_a (
      .CLK(CLK), .RST_IN(rst_n),
`ifdef LCD_TEST_PATTERN_EN
      .PATTERN_SEL(pat_sel),
`endif
      .DEN(a_den), .X(a_x), .Y(a_y), .R(a_r), .G(a_g), .B(a_b),
      .LCD_R(a_lr), .LCD_G(a_lg), .LCD_B(a_lb), .LCD_DE(a_lde),
      .LCD_HSYNC(a_lhs), .LCD_VSYNC(a_lvs), .FRAME_START(a_fs));

   lcd_timing_gen #(
      .H_ACTIVE(SH_A), .H_FP(SH_F), .H_SYNC(SH_S), .H_BP(SH_B),
      .V_ACTIVE(SV_A), .V_FP(SV_F), .V_SYNC(SV_S), .V_BP(SV_B),
      .SYNC_POL(1'b0), .CLIENT_LAT(3)
   ) u_b (
      .CLK(CLK), .RST_IN(rst_n),
`ifdef LCD_TEST_PATTERN_EN
      .PATTERN_SEL(pat_sel),
`endif
      .DEN(b_den), .X(b_x), .Y(b_y), .R(b_r), .G(b_g), .B(b_b),
      .LCD_R(b_lr), .LCD_G(b_lg), .LCD_B(b_lb), .LCD_DE(b_lde),
      .LCD_HSYNC(b_lhs), .LCD_VSYNC(b_lvs), .FRAME_START(b_fs));

   // Reference colour bars, left to right.
   function automatic logic [23:0] bar_ref(input int i);
      case (i)
         0: return 24'hFFFFFF;
         1: return 24'hFFFF00;
         2: return 24'h00FFFF;
         3: return 24'h00FF00;
         4: return 24'hFF00FF;
         5: return 24'hFF0000;
         6: return 24'h0000FF;
         default: return 24'h000000;
      endcase
   endfunction

   // Colour the panel must show for visible pixel (h,v).
   function automatic logic [23:0] pix_ref(input int h, input int v, input int ha);
      if (pat_on) return bar_ref(h / (ha / 8));
      return {8'(h), 8'(v ^ seed_g), 8'(h + 3 * v + seed_b)};
   endfunction

   // Client: a pixel function of X/Y when DEN=1, garbage otherwise.
   function automatic logic [23:0] client_pix(input logic den, input logic [10:0] x,
                                              input logic [10:0] y);
      if (den) return {x[7:0], 8'(int'(y) ^ seed_g), 8'(int'(x) + 3 * int'(y) + seed_b)};
      if ($urandom_range(0, 1) == 1) return 24'hFFFFFF;
      return 24'($urandom);
   endfunction

   // Expected outputs e cycles after reset release, from raster arithmetic.
   function automatic exp_t model(input int ha, input int hf, input int hs, input int hb,
                                  input int va, input int vf, input int vs, input int vb,
                                  input int lat, input bit pol, input int e);
      exp_t m;
      int ht, vt, p, h, v, q;
      ht = ha + hf + hs + hb;
      vt = va + vf + vs + vb;
      m = '0;
      p = e % (ht * vt);
      h = p % ht;
      v = p / ht;
      m.den = (h < ha) && (v < va);
      m.x   = m.den ? 11'(h) : 11'd0;
      m.y   = m.den ? 11'(v) : 11'd0;
      m.fs  = (p == 0);
      q = e - lat - 1;
      if (q < 0) begin
         m.lhs = ~pol;
         m.lvs = ~pol;
      end else begin
         p = q % (ht * vt);
         h = p % ht;
         v = p / ht;
         m.lde = (h < ha) && (v < va);
         m.lhs = (h >= ha + hf && h < ha + hf + hs) ? pol : ~pol;
         m.lvs = (v >= va + vf && v < va + vf + vs) ? pol : ~pol;
         m.rgb = m.lde ? pix_ref(h, v, ha) : 24'h000000;
      end
      return m;
   endfunction

   function automatic exp_t rst_exp(input bit pol);
      exp_t m;
      m = '0;
      m.lhs = ~pol;
      m.lvs = ~pol;
      return m;
   endfunction

   task automatic chk(input string tag, input int e, input logic [23:0] obs,
                      input logic [23:0] exp_v);
      vec_cnt++;
      assert (obs === exp_v) else begin
         err_cnt++;
         $error("FAIL %s @%0d: observed %0h, expected %0h", tag, e, obs, exp_v);
      end
   endtask

   task automatic check_one(input string nm, input int e, input exp_t m,
                            input logic den, input logic [10:0] x, input logic [10:0] y,
                            input logic fs, input logic lde, input logic lhs,
                            input logic lvs, input logic [7:0] r, input logic [7:0] g,
                            input logic [7:0] b);
      chk({nm, "_den"},   e, 24'(den), 24'(m.den));
      chk({nm, "_x"},     e, 24'(x),   24'(m.x));
      chk({nm, "_y"},     e, 24'(y),   24'(m.y));
      chk({nm, "_fs"},    e, 24'(fs),  24'(m.fs));
      chk({nm, "_lde"},   e, 24'(lde), 24'(m.lde));
      chk({nm, "_hsync"}, e, 24'(lhs), 24'(m.lhs));
      chk({nm, "_vsync"}, e, 24'(lvs), 24'(m.lvs));
      chk({nm, "_rgb"},   e, {r, g, b}, m.rgb);
   endtask

   task automatic check_all(input int e);
      check_one("def", e, model(480, 8, 4, 43, 272, 8, 4, 12, 1, 1'b0, e),
                d_den, d_x, d_y, d_fs, d_lde, d_lhs, d_lvs, d_lr, d_lg, d_lb);
      check_one("a", e, model(SH_A, SH_F, SH_S, SH_B, SV_A, SV_F, SV_S, SV_B, 1, 1'b1, e),
                a_den, a_x, a_y, a_fs, a_lde, a_lhs, a_lvs, a_lr, a_lg, a_lb);
      check_one("b", e, model(SH_A, SH_F, SH_S, SH_B, SV_A, SV_F, SV_S, SV_B, 3, 1'b0, e),
                b_den, b_x, b_y, b_fs, b_lde, b_lhs, b_lvs, b_lr, b_lg, b_lb);
   endtask

   task automatic check_reset(input int e);
      check_one("def_rst", e, rst_exp(1'b0),
                d_den, d_x, d_y, d_fs, d_lde, d_lhs, d_lvs, d_lr, d_lg, d_lb);
      check_one("a_rst", e, rst_exp(1'b1),
                a_den, a_x, a_y, a_fs, a_lde, a_lhs, a_lvs, a_lr, a_lg, a_lb);
      check_one("b_rst", e, rst_exp(1'b0),
                b_den, b_x, b_y, b_fs, b_lde, b_lhs, b_lvs, b_lr, b_lg, b_lb);
   endtask

   // Registered clients: present colour from L cycles ago, then record now.
   task automatic drive_clients();
      {d_r, d_g, d_b} = d_hist[0];
      {a_r, a_g, a_b} = a_hist[0];
      {b_r, b_g, b_b} = b_hist[2];
      for (int i = 3; i > 0; i--) begin
         d_hist[i] = d_hist[i-1];
         a_hist[i] = a_hist[i-1];
         b_hist[i] = b_hist[i-1];
      end
      d_hist[0] = client_pix(d_den, d_x, d_y);
      a_hist[0] = client_pix(a_den, a_x, a_y);
      b_hist[0] = client_pix(b_den, b_x, b_y);
   endtask

   initial begin
      int n1;
      rst_n   = 1'b0;
      pat_sel = 1'b0;
      pat_on  = 1'b0;
      seed_g  = int'($urandom_range(0, 255));
      seed_b  = int'($urandom_range(0, 255));
      for (int i = 0; i < 4; i++) begin
         d_hist[i] = 24'($urandom);
         a_hist[i] = 24'($urandom);
         b_hist[i] = 24'($urandom);
      end
      {d_r, d_g, d_b} = 24'hFFFFFF;
      {a_r, a_g, a_b} = 24'hFFFFFF;
      {b_r, b_g, b_b} = 24'hFFFFFF;

      // Reset state while clocks run.
      repeat (3) @(posedge CLK);
      #1;
      check_reset(-1);

      // First run: two-plus small frames, several default lines.
      @(negedge CLK);
      rst_n = 1'b1;
      n1 = 1500 + int'($urandom_range(0, 500));
      for (int e = 0; e < n1; e++) begin
         @(posedge CLK);
         #1;
         drive_clients();
         check_all(e);
         if (e == 481) chk("def_last_px", e, {16'h0000, d_lr}, 24'h0000DF);
      end

      // Asynchronous reset mid-cycle: outputs must drop before any edge.
      #3;
      rst_n = 1'b0;
      #1;
      check_reset(-2);
      if (PAT_EN) begin
         pat_sel = 1'b1;
         pat_on  = 1'b1;
      end
      @(posedge CLK);
      #1;
      check_reset(-3);

      // Restart from pixel (0,0), with test bars when that build is in use.
      @(negedge CLK);
      rst_n = 1'b1;
      for (int e = 0; e < 1200; e++) begin
         @(posedge CLK);
         #1;
         drive_clients();
         check_all(e);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule

// File: doc/lcd_timing_gen.md
Name: lcd_timing_gen

Overview:
Pixel-interface master for the parallel RGB LCD, paired with the pixel-client blocks such as the game renderers.
- Generates the horizontal and vertical timing.
- Presents DEN, X and Y to the client, then takes back the client's registered R/G/B.
- Re-aligns sync and data-enable with that returned colour and drives the panel pins.
- Emits a frame-start strobe for game-logic pacing.

Parameters:
- H_ACTIVE, 480, visible pixels per line
- H_FP, 8, horizontal front porch (cycles)
- H_SYNC, 4, HSYNC pulse width
- H_BP, 43, horizontal back porch
- V_ACTIVE, 272, visible lines per frame
- V_FP, 8, vertical front porch (lines)
- V_SYNC, 4, VSYNC pulse width (lines)
- V_BP, 12, vertical back porch
- SYNC_POL, 0, 0 = active-low HSYNC/VSYNC, 1 = active-high
- CLIENT_LAT, 1, client colour latency in cycles, legal range 1..4

Ports:
- CLK  in  1  pixel clock
- RST_IN  in  1  asynchronous active-low reset
- DEN  out  1  active-region flag to client, undelayed
- X  out  11  pixel column to client; 0..H_ACTIVE-1 when DEN=1, 0 otherwise
- Y  out  11  line number to client; 0..V_ACTIVE-1 when DEN=1, 0 otherwise
- R, G, B  in  8 each  client colour, valid CLIENT_LAT cycles after the matching DEN/X/Y
- LCD_R, LCD_G, LCD_B  out  8 each  panel colour
- LCD_DE  out  1  panel data enable
- LCD_HSYNC  out  1  panel HSYNC
- LCD_VSYNC  out  1  panel VSYNC
- FRAME_START  out  1  one-cycle pulse at hcnt=0, vcnt=0, undelayed

Behaviour:
- Counters:
  - hcnt runs 0..H_TOTAL-1, where H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (535 at defaults).
  - vcnt runs 0..V_TOTAL-1 (296 at defaults) and increments only when hcnt wraps.
  - vcnt wraps to 0 when hcnt wraps while vcnt = V_TOTAL-1.
- Line and frame order: active, front porch, sync, back porch.
  - Horizontal sync is asserted for hcnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1].
  - Vertical sync uses the same rule on vcnt, with V_* parameters.
- DEN = (hcnt < H_ACTIVE) && (vcnt < V_ACTIVE).
  - DEN, X and Y are registered outputs of the counter stage, all updated on the same edge.
- Alignment pipeline:
  - Raw DE, HS and VS pass through a CLIENT_LAT-deep shift register.
  - LCD_DE, LCD_HSYNC and LCD_VSYNC are the last stage.
  - Sync outputs: active level = SYNC_POL, idle level = ~SYNC_POL.
- Colour gating:
  - LCD_R/G/B = R/G/B when the delayed DE = 1, otherwise 8'h00. This suppresses client garbage in blanking.
  - Colour is registered one extra stage, together with a one-stage extension of the DE/HS/VS pipeline, so all panel pins change on the same edge.
- Reset:
  - Counters go to 0 and all pipeline stages go to inactive.
  - LCD_DE = 0, syncs idle (~SYNC_POL), LCD_R/G/B = 0, DEN = 0, X = Y = 0, FRAME_START = 0.
  - Reset mid-frame aborts the frame; after release, the first cycle restarts at hcnt=0, vcnt=0 and FRAME_START pulses.
- FRAME_START pulses once per frame, exactly V_TOTAL*H_TOTAL cycles apart (158 360 at defaults).
- Width rules:
  - Counters are 11 bits; H_TOTAL and V_TOTAL must be ≤ 2047.
  - A CLIENT_LAT outside 1..4 is an elaboration error.

Optional Feature:
- Macro: LCD_TEST_PATTERN_EN.
- When defined:
  - Adds input PATTERN_SEL (1 bit).
  - With PATTERN_SEL = 1, the colour stage ignores R/G/B and outputs 8 vertical bars, each H_ACTIVE/8 = 60 px wide: white, yellow, cyan, green, magenta, red, blue, black.
  - Bar colour is computed from the delayed X so its latency equals the client path.
  - Blanking gating still applies.
- When undefined: PATTERN_SEL does not exist and client colour is always used.

Decomposition:
- Package lcd_timing_pkg holds:
  - the default timing constants (H_ACTIVE, H_FP, H_SYNC, H_BP, V_* and the derived H_TOTAL/V_TOTAL);
  - the 11-bit coordinate width;
  - the 24-bit colour-bar constants.
- Sub-module lcd_delay_line: parameterised depth and width, async active-low reset to a parameter value. Used for the DE/HS/VS alignment and, under the macro, for X.

Test Plan:
- Release reset, run 2 frames:
  - FRAME_START pulses at cycle 0 and cycle 158 360.
  - LCD_HSYNC is low for 4 cycles per 535-cycle line.
  - LCD_VSYNC is low for 4 lines (2140 cycles) per frame.
- Client model returns R = X[7:0], registered (latency 1):
  - LCD_DE rises on the cycle LCD_R = 0.
  - LCD_R = 8'hDF on the 480th DE-high cycle of the line, the last pixel.
  - LCD_R = 0 during every blanking cycle.
- Client drives constant 8'hFF on R/G/B during blanking → LCD_R/G/B stay 8'h00 whenever LCD_DE = 0.
- Set CLIENT_LAT = 3 with a matching 3-stage client → same pixel/DE alignment as CLIENT_LAT = 1, with all panel pins shifted by 2 cycles.
- Assert RST_IN low at hcnt = 200, vcnt = 100, asynchronously mid-cycle:
  - outputs go to reset values immediately, without waiting for a clock edge;
  - after release, X/Y restart at 0,0 and FRAME_START pulses.
- With LCD_TEST_PATTERN_EN defined and PATTERN_SEL = 1:
  - pixel X = 59 → FFFFFF; X = 60 → FFFF00; X = 479 → 000000.
  - PATTERN_SEL = 0 → client colour.
